// File: rtl/booth4_mul_unit.sv
// Iterative radix-4 Booth multiplier for the RV32IM M-extension execute stage.
// Handles MUL/MULH/MULHSU/MULHU by extending both operands to XLEN+2 bits and
// running a signed (XLEN+2)x(XLEN+2) Booth recode, UNROLL digits per cycle.
module booth4_mul_unit #(
    parameter int XLEN   = 32,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            flush,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [1:0]      op,
    input  logic [XLEN-1:0] rs1,
    input  logic [XLEN-1:0] rs2,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            busy
);

    localparam int W  = XLEN + 2;
    localparam int D  = W / 2;
    localparam int C  = (D + UNROLL - 1) / UNROLL;
    localparam int CW = (C > 1) ? $clog2(C) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t                r_state;
    logic [CW-1:0]         r_cnt;
    logic signed [W+1:0]   r_ac;
    logic [W:0]            r_q;      // multiplier bits above the Booth guard bit r_q[0]
    logic signed [W+1:0]   r_pm;
    logic signed [W+1:0]   r_p2m;
    logic signed [W+1:0]   r_nm;
    logic signed [W+1:0]   r_n2m;
    logic                  r_hi;
    logic [XLEN-1:0]       r_result;

    logic                  w_s1;
    logic                  w_s2;
    logic signed [W+1:0]   w_mcand;
    logic signed [W+1:0]   w_ac_nxt;
    logic [W:0]            w_q_nxt;
    logic [2*W-1:0]        w_prod;
    logic [XLEN-1:0]       w_res;
    logic                  w_unused;

    // Booth digit {q[i+1], q[i], q[i-1]} selects one of the precomputed multiples
    function automatic logic signed [W+1:0] booth_sel(
        input logic [2:0]          dig,
        input logic signed [W+1:0] pm,
        input logic signed [W+1:0] p2m,
        input logic signed [W+1:0] nm,
        input logic signed [W+1:0] n2m
    );
        case (dig)
            3'b001, 3'b010: booth_sel = pm;
            3'b011:         booth_sel = p2m;
            3'b100:         booth_sel = n2m;
            3'b101, 3'b110: booth_sel = nm;
            default:        booth_sel = '0;
        endcase
    endfunction

    // Signedness per op: rs1 unsigned only for MULHU, rs2 unsigned for MULHSU/MULHU
    assign w_s1    = (op != 2'b11) & rs1[XLEN-1];
    assign w_s2    = ~op[1] & rs2[XLEN-1];
    assign w_mcand = {{4{w_s1}}, rs1};

    // Retire up to UNROLL digits; digits beyond D hold state so the product stays aligned
    always_comb begin
        w_ac_nxt = r_ac;
        w_q_nxt  = r_q;
        for (int u = 0; u < UNROLL; u++) begin
            if (int'(r_cnt) * UNROLL + u < D) begin
                w_ac_nxt = w_ac_nxt + booth_sel(w_q_nxt[2:0], r_pm, r_p2m, r_nm, r_n2m);
                w_q_nxt  = {w_ac_nxt[1:0], w_q_nxt[W:2]};
                w_ac_nxt = w_ac_nxt >>> 2;
            end
        end
    end

    // Low 2W bits of {AC,Q} hold the product once all D digits are retired
    assign w_prod   = {w_ac_nxt[W-1:0], w_q_nxt[W:1]};
    assign w_res    = r_hi ? w_prod[2*XLEN-1:XLEN] : w_prod[XLEN-1:0];
    assign w_unused = ^w_prod[2*W-1:2*XLEN];

    // Control FSM and iterative datapath; flush aborts anything in flight
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= S_IDLE;
            r_cnt    <= '0;
            r_ac     <= '0;
            r_q      <= '0;
            r_pm     <= '0;
            r_p2m    <= '0;
            r_nm     <= '0;
            r_n2m    <= '0;
            r_hi     <= 1'b0;
            r_result <= '0;
        end else if (flush) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_ac    <= '0;
                        r_q     <= {w_s2, w_s2, rs2, 1'b0};
                        r_pm    <= w_mcand;
                        r_p2m   <= w_mcand <<< 1;
                        r_nm    <= -w_mcand;
                        r_n2m   <= -(w_mcand <<< 1);
                        r_hi    <= (op != 2'b00);
                        r_cnt   <= '0;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    r_ac  <= w_ac_nxt;
                    r_q   <= w_q_nxt;
                    r_cnt <= r_cnt + 1'b1;
                    if (r_cnt == CW'(C - 1)) begin
                        r_result <= w_res;
                        r_state  <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE);
    assign out_valid = (r_state == S_DONE);
    assign busy      = (r_state != S_IDLE);
    assign result    = r_result;

endmodule

// File: tb/tb_booth4_mul_unit.sv
// Testbench for booth4_mul_unit: four instances (UNROLL 1,2,4,17) share the
// input bus; directed handshake/flush/reset steps then randomized ops against
// a wide-integer reference model.
module tb_booth4_mul_unit;

    logic        clk = 1'b0;
    logic        rst;
    logic        flush;
    logic        in_valid;
    logic [1:0]  op;
    logic [31:0] rs1;
    logic [31:0] rs2;
    logic [3:0]  in_ready;
    logic [3:0]  out_valid;
    logic [3:0]  out_ready;
    logic [3:0]  busy;
    logic [31:0] result [4];

    int tests = 0;
    int fails = 0;

    logic [31:0] corners [5] = '{32'h0, 32'h1, 32'hFFFFFFFF, 32'h80000000, 32'h7FFFFFFF};

    always #5 clk = ~clk;

    for (genvar g = 0; g < 4; g++) begin : g_dut
        booth4_mul_unit #(
            .XLEN  (32),
            .UNROLL(g == 0 ? 1 : g == 1 ? 2 : g == 2 ? 4 : 17)
        ) u_dut (
            .clk      (clk),
            .rst      (rst),
            .flush    (flush),
            .in_valid (in_valid),
            .in_ready (in_ready[g]),
            .op       (op),
            .rs1      (rs1),
            .rs2      (rs2),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g]),
            .result   (result[g]),
            .busy     (busy[g])
        );
    end

    function automatic int unroll_of(input int g);
        return (g == 0) ? 1 : (g == 1) ? 2 : (g == 2) ? 4 : 17;
    endfunction

    // 17 digits for 34-bit operands; one accept edge plus ceil(17/U) RUN edges
    function automatic int exp_lat(input int g);
        return (17 + unroll_of(g) - 1) / unroll_of(g) + 1;
    endfunction

    function automatic logic [31:0] ref_mul(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
        logic signed [127:0] a;
        logic signed [127:0] b;
        logic signed [127:0] p;
        a = (o == 2'b11) ? {96'b0, x} : {{96{x[31]}}, x};
        b = o[1] ? {96'b0, y} : {{96{y[31]}}, y};
        p = a * b;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    function automatic logic [31:0] pick_operand();
        if ($urandom_range(0, 3) == 0) return corners[$urandom_range(0, 4)];
        return $urandom;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        op       = o;
        rs1      = a;
        rs2      = b;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        op       = 2'($urandom);
        rs1      = $urandom;
        rs2      = $urandom;
    endtask

    task automatic wait_done0(output int lat);
        lat = 1;
        while (!out_valid[0] && lat < 100) begin
            step();
            lat++;
        end
    endtask

    task automatic wait_all_idle(input string tag);
        int n;
        n = 0;
        while (in_ready !== 4'hF && n < 100) begin
            step();
            n++;
        end
        chk(tag, {28'b0, in_ready}, 32'hF);
    endtask

    task automatic directed0(input string tag, input logic [1:0] o, input logic [31:0] a,
                             input logic [31:0] b, input logic [31:0] exp);
        int lat;
        issue(o, a, b);
        wait_done0(lat);
        chk({tag, "_lat"}, lat, 18);
        chk({tag, "_res"}, result[0], exp);
        step();
        wait_all_idle({tag, "_idle"});
    endtask

    initial begin
        int          lat;
        int          seen;
        logic [31:0] exp;
        logic [3:0]  done;
        logic [1:0]  o;
        logic [31:0] a;
        logic [31:0] b;

        rst       = 1'b1;
        flush     = 1'b0;
        in_valid  = 1'b0;
        op        = 2'b00;
        rs1       = '0;
        rs2       = '0;
        out_ready = 4'hF;
        repeat (3) step();

        for (int g = 0; g < 4; g++) begin
            chk("rst_in_ready", {31'b0, in_ready[g]}, 32'd1);
            chk("rst_out_valid", {31'b0, out_valid[g]}, 32'd0);
            chk("rst_busy", {31'b0, busy[g]}, 32'd0);
            chk("rst_result", result[g], 32'd0);
        end
        rst = 1'b0;
        step();

        directed0("mul_7x-3", 2'b00, 32'd7, 32'hFFFFFFFD, 32'hFFFFFFEB);
        directed0("mulh_min", 2'b01, 32'h80000000, 32'h80000000, 32'h40000000);
        directed0("mul_min", 2'b00, 32'h80000000, 32'h80000000, 32'h00000000);
        directed0("mulhu_ones", 2'b11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
        directed0("mulhsu_ones", 2'b10, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF);

        // Back-pressure: hold DONE for 10 cycles, then release and re-accept
        out_ready[0] = 1'b0;
        exp = ref_mul(2'b01, 32'h12345678, 32'h9ABCDEF0);
        issue(2'b01, 32'h12345678, 32'h9ABCDEF0);
        wait_done0(lat);
        chk("bp_lat", lat, 18);
        for (int i = 0; i < 10; i++) begin
            step();
            chk("bp_out_valid", {31'b0, out_valid[0]}, 32'd1);
            chk("bp_result", result[0], exp);
            chk("bp_in_ready", {31'b0, in_ready[0]}, 32'd0);
        end
        out_ready[0] = 1'b1;
        chk("bp_release_in_ready", {31'b0, in_ready[0]}, 32'd0);
        op       = 2'b00;
        rs1      = 32'd1000;
        rs2      = 32'hFFFFFC18;
        in_valid = 1'b1;
        step();
        chk("bp_no_same_cycle", {31'b0, busy[0]}, 32'd0);
        step();
        in_valid = 1'b0;
        chk("bp_next_accepted", {31'b0, busy[0]}, 32'd1);
        wait_done0(lat);
        chk("bp_next_lat", lat, 18);
        chk("bp_next_res", result[0], 32'hFFF0BDC0);
        step();
        wait_all_idle("bp_idle");

        // Flush at the fifth RUN cycle
        issue(2'b00, 32'd123, 32'd456);
        repeat (4) step();
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_run_out_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("flush_run_busy", {31'b0, busy[0]}, 32'd0);
        chk("flush_run_in_ready", {31'b0, in_ready[0]}, 32'd1);
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            if (out_valid[0]) seen++;
            step();
        end
        chk("flush_run_no_result", seen, 0);

        // Flush together with in_valid in IDLE: nothing accepted
        wait_all_idle("flush_idle_pre");
        in_valid = 1'b1;
        flush    = 1'b1;
        step();
        in_valid = 1'b0;
        flush    = 1'b0;
        chk("flush_idle_busy", {28'b0, busy}, 32'd0);

        // Flush while DONE is held
        out_ready[0] = 1'b0;
        issue(2'b00, 32'd5, 32'd6);
        wait_done0(lat);
        chk("flush_done_reached", {31'b0, out_valid[0]}, 32'd1);
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_done_out_valid", {31'b0, out_valid[0]}, 32'd0);
        chk("flush_done_in_ready", {31'b0, in_ready[0]}, 32'd1);
        out_ready[0] = 1'b1;
        wait_all_idle("flush_done_idle");

        // Asynchronous reset in the middle of RUN
        issue(2'b01, 32'hDEADBEEF, 32'h0BADF00D);
        repeat (3) step();
        #2 rst = 1'b1;
        #1;
        chk("rst_mid_in_ready", {28'b0, in_ready}, 32'hF);
        chk("rst_mid_out_valid", {28'b0, out_valid}, 32'h0);
        chk("rst_mid_busy", {28'b0, busy}, 32'h0);
        chk("rst_mid_result", result[0], 32'd0);
        step();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 25; i++) begin
            step();
            if (out_valid != 4'h0) seen++;
        end
        chk("rst_mid_no_stale", seen, 0);

        // Randomized ops across all modes and all four UNROLL settings
        out_ready = 4'hF;
        for (int n = 0; n < 2000; n++) begin
            chk("rnd_idle", {28'b0, in_ready}, 32'hF);
            o   = 2'($urandom_range(0, 3));
            a   = pick_operand();
            b   = pick_operand();
            exp = ref_mul(o, a, b);
            issue(o, a, b);
            done = 4'h0;
            lat  = 1;
            while (done != 4'hF && lat < 40) begin
                for (int g = 0; g < 4; g++) begin
                    if (!done[g] && out_valid[g]) begin
                        chk($sformatf("rnd_res_u%0d_op%0d_%h_%h", unroll_of(g), o, a, b), result[g], exp);
                        chk($sformatf("rnd_lat_u%0d", unroll_of(g)), lat, exp_lat(g));
                        done[g] = 1'b1;
                    end
                end
                if (done != 4'hF) begin
                    step();
                    lat++;
                end
            end
            if (done != 4'hF) chk("rnd_timeout", {28'b0, done}, 32'hF);
            step();
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
